// File: rtl/nrf_pkg.sv
// nrf_pkg -- shared definitions for the nRF24L01 SPI transaction sequencer.
//
// Contents:
//   MAX_LEN_DEF   default data-byte limit per transaction (nRF payload size)
//   LEN_W         width of the per-requester length fields
//   command bytes R_REGISTER, W_REGISTER, R_RX_PAYLOAD, W_TX_PAYLOAD, NOP
//   seq_state_t   sequencer state encoding
//   clamp_len()   saturates a requested length at the data-byte limit
package nrf_pkg;

    localparam int MAX_LEN_DEF = 32;
    localparam int LEN_W       = 6;

    localparam logic [7:0] R_REGISTER   = 8'h00;
    localparam logic [7:0] W_REGISTER   = 8'h20;
    localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] NOP          = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } seq_state_t;

    // A length field can encode up to 63 bytes but the radio accepts at most
    // max_len per transaction; anything larger is cut down rather than rejected.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int max_len);
        if (int'(len) > max_len)
            return LEN_W'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/nrf_rr_arb.sv
// nrf_rr_arb -- two-way round-robin arbiter for the SPI sequencer.
//
// Ports:
//   clk_10  in   system clock
//   rst     in   asynchronous active-high reset (requester 0 preferred)
//   req     in   [1:0] request levels
//   upd     in   pulse: the transaction owned by 'last' has finished
//   last    in   [1:0] one-hot owner of the finishing transaction
//   win     out  [1:0] one-hot combinational winner for the current req
//
// The priority pointer only moves when a transaction completes, so an
// aborted-by-reset transaction leaves the pointer at its reset value.
module nrf_rr_arb (
    input  logic       clk_10,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic [1:0] last,
    output logic [1:0] win
);

    // prio = 1: requester 1 wins a tie; prio = 0: requester 0 wins a tie
    logic prio;

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst)
            prio <= 1'b0;
        else if (upd)
            prio <= last[0] & ~last[1];   // the one not just served goes first
    end

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = prio ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/nrf_spi_sequencer.sv
// nrf_spi_sequencer -- transaction-level controller for the nRF24L01 SPI link.
//
// Arbitrates between a configuration requester (0) and a payload requester (1),
// then runs one command byte plus 0..MAX_LEN data bytes over a single-byte SPI
// engine while holding CSN low for the whole transaction.
//
// Ports:
//   clk_10, rst            clock; asynchronous active-high reset
//   req[1:0]               request levels, held until done
//   req0_cmd/req1_cmd      command byte per requester
//   req0_len/req1_len      data byte count per requester (clamped to MAX_LEN)
//   grant[1:0]             one-hot owner for the whole transaction
//   tx_data / tx_take      write byte from owner / pulse when it is sampled
//   rx_data / rx_valid     byte read during a data phase / one-cycle strobe
//   status                 byte clocked in during the command byte
//   done / err             transaction finished / finished by timeout
//   busy                   high from grant until the CSN idle gap expires
//   eng_start/eng_tx       byte engine kick and byte to shift out
//   eng_rx/eng_done        byte engine result and completion pulse
//   csn                    radio chip select, active low
//
// All outputs are registered: the combinational process computes next values
// for every output and the state register process loads them.
module nrf_spi_sequencer
    import nrf_pkg::*;
#(
    parameter int MAX_LEN   = MAX_LEN_DEF,
    parameter int CSN_SETUP = 2,
    parameter int CSN_HOLD  = 2,
    parameter int CSN_IDLE  = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk_10,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [7:0]       req0_cmd,
    input  logic [7:0]       req1_cmd,
    input  logic [LEN_W-1:0] req0_len,
    input  logic [LEN_W-1:0] req1_len,
    output logic [1:0]       grant,
    input  logic [7:0]       tx_data,
    output logic             tx_take,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [7:0]       status,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             eng_start,
    output logic [7:0]       eng_tx,
    input  logic [7:0]       eng_rx,
    input  logic             eng_done,
    output logic             csn
);

    // Phase counter serves SETUP, HOLD and GAP; the three delays stay below 256.
    localparam int CNT_W  = 8;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              wait_q, wait_d;     // DATA: engine byte in flight
    logic              abort_q, abort_d;   // transaction ended by timeout

    logic [1:0]        grant_d;
    logic              tx_take_d, rx_valid_d, done_d, err_d, busy_d;
    logic              eng_start_d, csn_d;
    logic [7:0]        rx_data_d, status_d, eng_tx_d;

    logic [1:0]        arb_win;
    logic              arb_upd;
    logic              wait_expired;

    nrf_rr_arb u_arb (
        .clk_10 (clk_10),
        .rst    (rst),
        .req    (req),
        .upd    (arb_upd),
        .last   (grant),
        .win    (arb_win)
    );

    // The wait counter is cleared on every eng_start, so this fires TIMEOUT
    // cycles after the most recent byte was kicked off.
    assign wait_expired = (wcnt_q == WCNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        cmd_d       = cmd_q;
        rem_d       = rem_q;
        wait_d      = wait_q;
        abort_d     = abort_q;
        grant_d     = grant;
        csn_d       = csn;
        busy_d      = busy;
        status_d    = status;
        rx_data_d   = rx_data;
        eng_tx_d    = eng_tx;
        tx_take_d   = 1'b0;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        eng_start_d = 1'b0;
        arb_upd     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_win != 2'b00) begin
                    grant_d = arb_win;
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    cmd_d   = arb_win[1] ? req1_cmd : req0_cmd;
                    rem_d   = clamp_len(arb_win[1] ? req1_len : req0_len, MAX_LEN);
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == CNT_W'(CSN_SETUP - 1)) begin
                    eng_start_d = 1'b1;
                    eng_tx_d    = cmd_q;
                    wcnt_d      = '0;
                    state_d     = ST_CMD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CMD: begin
                if (eng_done) begin
                    status_d = eng_rx;
                    if (rem_q == '0) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        tx_take_d = 1'b1;
                        wait_d    = 1'b0;
                        state_d   = ST_DATA;
                    end
                end else if (wait_expired) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end

            ST_DATA: begin
                if (!wait_q) begin
                    // tx_take is high this cycle: the owner's byte is valid now
                    eng_start_d = 1'b1;
                    eng_tx_d    = tx_data;
                    wcnt_d      = '0;
                    wait_d      = 1'b1;
                end else if (eng_done) begin
                    rx_data_d  = eng_rx;
                    rx_valid_d = 1'b1;
                    rem_d      = rem_q - LEN_W'(1);
                    wait_d     = 1'b0;
                    if (rem_q == LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        tx_take_d = 1'b1;
                    end
                end else if (wait_expired) begin
                    // remaining bytes are dropped; no further tx_take
                    abort_d = 1'b1;
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(CSN_HOLD - 1)) begin
                    csn_d   = 1'b1;
                    done_d  = 1'b1;
                    err_d   = abort_q;
                    grant_d = 2'b00;
                    arb_upd = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(CSN_IDLE - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            cmd_q     <= '0;
            rem_q     <= '0;
            wait_q    <= 1'b0;
            abort_q   <= 1'b0;
            grant     <= 2'b00;
            csn       <= 1'b1;
            busy      <= 1'b0;
            status    <= '0;
            rx_data   <= '0;
            eng_tx    <= '0;
            tx_take   <= 1'b0;
            rx_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            eng_start <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            cmd_q     <= cmd_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            abort_q   <= abort_d;
            grant     <= grant_d;
            csn       <= csn_d;
            busy      <= busy_d;
            status    <= status_d;
            rx_data   <= rx_data_d;
            eng_tx    <= eng_tx_d;
            tx_take   <= tx_take_d;
            rx_valid  <= rx_valid_d;
            done      <= done_d;
            err       <= err_d;
            eng_start <= eng_start_d;
        end
    end

endmodule

// File: tb/tb_nrf_spi_sequencer.sv
// Scoreboard bench for nrf_spi_sequencer: stimulus pushes expected transactions,
// engine bytes and read bytes into queues; a monitor, an engine model and a
// requester model consume them as the DUT produces activity.
module tb_nrf_spi_sequencer;
    import nrf_pkg::*;

    localparam int CSN_SETUP = 2;
    localparam int CSN_HOLD  = 2;
    localparam int CSN_IDLE  = 5;
    localparam int TIMEOUT   = 64;
    localparam int ENG_LAT   = 3;

    logic       clk_10 = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [7:0] req0_cmd = 8'h00, req1_cmd = 8'h00;
    logic [5:0] req0_len = 6'd0,  req1_len = 6'd0;
    logic [1:0] grant;
    logic [7:0] tx_data;
    logic       tx_take;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] status;
    logic       done, err, busy;
    logic       eng_start;
    logic [7:0] eng_tx;
    logic [7:0] eng_rx;
    logic       eng_done;
    logic       csn;

    nrf_spi_sequencer #(
        .MAX_LEN(32), .CSN_SETUP(CSN_SETUP), .CSN_HOLD(CSN_HOLD),
        .CSN_IDLE(CSN_IDLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_10(clk_10), .rst(rst), .req(req),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .req0_len(req0_len), .req1_len(req1_len),
        .grant(grant), .tx_data(tx_data), .tx_take(tx_take),
        .rx_data(rx_data), .rx_valid(rx_valid), .status(status),
        .done(done), .err(err), .busy(busy),
        .eng_start(eng_start), .eng_tx(eng_tx), .eng_rx(eng_rx),
        .eng_done(eng_done), .csn(csn)
    );

    initial forever #50 clk_10 = ~clk_10;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] status;
        logic       err;
        int         takes;
        int         starts;
        int         tail;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       hold;
    } resp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    resp_t      resp_q[$];
    logic [7:0] txq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Tail: cycles from the last engine reply (or, on abort, the last kick) to CSN rising.
    task automatic push_exp(input logic [1:0] owner, input logic [7:0] st,
                            input logic e, input int takes, input int starts);
        exp_t x;
        x.owner  = owner;
        x.status = st;
        x.err    = e;
        x.takes  = takes;
        x.starts = starts;
        x.tail   = e ? (TIMEOUT + CSN_HOLD) : (CSN_HOLD + 1);
        exp_q.push_back(x);
    endtask

    task automatic push_resp(input logic [7:0] b, input logic hold);
        resp_t r;
        r.b    = b;
        r.hold = hold;
        resp_q.push_back(r);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk_10);
            n++;
        end while (!done && n < 3000);
        if (!done) chk(name, 0, 1);
    endtask

    // ---------------- engine model ----------------
    resp_t eng_r;
    initial begin
        eng_done = 1'b0;
        eng_rx   = 8'h00;
        forever begin
            @(negedge clk_10);
            if (!rst && eng_start) begin
                if (exp_tx_q.size() == 0) chk("eng_tx_unexpected", 1, 0);
                else chk("eng_tx", int'(eng_tx), int'(exp_tx_q.pop_front()));
                if (resp_q.size() == 0) begin
                    eng_r.b    = 8'h00;
                    eng_r.hold = 1'b1;
                end else begin
                    eng_r = resp_q.pop_front();
                end
                if (!eng_r.hold) begin
                    repeat (ENG_LAT) @(posedge clk_10);
                    #1;
                    eng_done = 1'b1;
                    eng_rx   = eng_r.b;
                    @(posedge clk_10);
                    #1;
                    eng_done = 1'b0;
                    eng_rx   = 8'h00;
                end
            end
        end
    end

    // ---------------- requester model: presents head of txq, 0xFF when empty ----------------
    initial begin
        tx_data = 8'hFF;
        forever begin
            @(negedge clk_10);
            if (!rst && tx_take) begin
                @(posedge clk_10);
                #1;
                if (txq.size() != 0) void'(txq.pop_front());
            end
            tx_data = (txq.size() != 0) ? txq[0] : 8'hFF;
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0, fall_cyc = 0, rise_cyc = 0, last_start = 0, last_done = 0;
    int         m_takes = 0, m_starts = 0;
    bit         have_rise = 0, first_start = 0;
    logic [1:0] m_owner = 2'b00;
    logic       csn_prev = 1'b1;
    exp_t       me;

    initial forever begin
        @(negedge clk_10);
        cyc++;
        if (rst) begin
            have_rise = 0;
            csn_prev  = 1'b1;
        end else begin
            if (csn_prev && !csn) begin
                fall_cyc    = cyc;
                m_owner     = grant;
                m_takes     = 0;
                m_starts    = 0;
                first_start = 1;
                chk("grant_onehot_at_csn_fall", int'($onehot(grant)), 1);
                chk("busy_at_csn_fall", int'(busy), 1);
                if (have_rise) chk("csn_idle_gap_ok", int'((cyc - rise_cyc) >= CSN_IDLE), 1);
            end
            if (!csn) begin
                if (eng_start) begin
                    m_starts++;
                    last_start = cyc;
                    if (first_start) begin
                        chk("csn_setup_cycles", cyc - fall_cyc, CSN_SETUP);
                        first_start = 0;
                    end
                end
                if (tx_take)  m_takes++;
                if (eng_done) last_done = cyc;
            end
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) chk("rx_valid_unexpected", 1, 0);
                else chk("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("owner",       int'(m_owner), int'(me.owner));
                    chk("status",      int'(status),  int'(me.status));
                    chk("err",         int'(err),     int'(me.err));
                    chk("tx_take_cnt", m_takes,       me.takes);
                    chk("eng_start_cnt", m_starts,    me.starts);
                    chk("csn_high_at_done", int'(csn), 1);
                    chk("grant_clear_at_done", int'(grant), 0);
                    chk("csn_tail_cycles", me.err ? (cyc - last_start) : (cyc - last_done), me.tail);
                end
            end
            if (!csn_prev && csn) begin
                rise_cyc  = cyc;
                have_rise = 1;
            end
            csn_prev = csn;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (20000) @(posedge clk_10);
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int got;
        int n;
        #5 rst = 1'b1;
        repeat (3) @(negedge clk_10);
        chk("reset_csn",   int'(csn), 1);
        chk("reset_grant", int'(grant), 0);
        chk("reset_pulses", int'({eng_start, tx_take, rx_valid, done, err, busy}), 0);
        chk("reset_bytes",  int'({eng_tx, rx_data, status}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_10);

        // 1: config write, one byte
        req0_cmd = W_REGISTER; req0_len = 6'd1;
        txq.push_back(8'h0E);
        exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h0E);
        push_resp(8'h0E, 0); push_resp(8'h00, 0);
        exp_rx_q.push_back(8'h00);
        push_exp(2'b01, 8'h0E, 0, 1, 2);
        req = 2'b01;
        wait_done("t1_done");
        req = 2'b00;

        // 2: payload read, three bytes, dummy 0xFF writes
        req1_cmd = R_RX_PAYLOAD; req1_len = 6'd3;
        exp_tx_q.push_back(8'h61);
        for (int i = 0; i < 3; i++) exp_tx_q.push_back(8'hFF);
        push_resp(8'h40, 0); push_resp(8'hAA, 0); push_resp(8'hBB, 0); push_resp(8'hCC, 0);
        exp_rx_q.push_back(8'hAA); exp_rx_q.push_back(8'hBB); exp_rx_q.push_back(8'hCC);
        push_exp(2'b10, 8'h40, 0, 3, 4);
        req = 2'b10;
        wait_done("t2_done");
        req = 2'b00;

        // 3: both requesting, grants alternate 01,10,01
        req0_cmd = W_REGISTER;   req0_len = 6'd1;
        req1_cmd = W_TX_PAYLOAD; req1_len = 6'd1;
        txq.push_back(8'h01); txq.push_back(8'h02); txq.push_back(8'h03);
        exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'hA0); exp_tx_q.push_back(8'h02);
        exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h03);
        push_resp(8'h0E, 0); push_resp(8'h11, 0);
        push_resp(8'h2E, 0); push_resp(8'h22, 0);
        push_resp(8'h0E, 0); push_resp(8'h33, 0);
        exp_rx_q.push_back(8'h11); exp_rx_q.push_back(8'h22); exp_rx_q.push_back(8'h33);
        push_exp(2'b01, 8'h0E, 0, 1, 2);
        push_exp(2'b10, 8'h2E, 0, 1, 2);
        push_exp(2'b01, 8'h0E, 0, 1, 2);
        req = 2'b11;
        wait_done("t3a_done");
        wait_done("t3b_done");
        wait_done("t3c_done");
        req = 2'b00;

        // 4: command only
        req0_cmd = NOP; req0_len = 6'd0;
        exp_tx_q.push_back(8'hFF);
        push_resp(8'h0E, 0);
        push_exp(2'b01, 8'h0E, 0, 0, 1);
        req = 2'b01;
        wait_done("t4_done");
        req = 2'b00;

        // 5: length 40 clamps to 32
        req1_cmd = R_RX_PAYLOAD; req1_len = 6'd40;
        exp_tx_q.push_back(8'h61);
        push_resp(8'h40, 0);
        for (int i = 0; i < 32; i++) begin
            exp_tx_q.push_back(8'hFF);
            push_resp(8'h80 + 8'(i), 0);
            exp_rx_q.push_back(8'h80 + 8'(i));
        end
        push_exp(2'b10, 8'h40, 0, 32, 33);
        req = 2'b10;
        wait_done("t5_done");
        req = 2'b00;

        // 6: engine silent on data byte 2 -> timeout abort
        req0_cmd = W_TX_PAYLOAD; req0_len = 6'd4;
        txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); txq.push_back(8'h44);
        exp_tx_q.push_back(8'hA0); exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
        push_resp(8'h0E, 0); push_resp(8'h00, 0); push_resp(8'h00, 1);
        exp_rx_q.push_back(8'h00);
        push_exp(2'b01, 8'h0E, 1, 2, 3);
        req = 2'b01;
        wait_done("t6_done");
        req = 2'b00;
        txq.delete();

        // 7: reset in the middle of the data phase
        repeat (10) @(negedge clk_10);
        req1_cmd = R_RX_PAYLOAD; req1_len = 6'd4;
        exp_tx_q.push_back(8'h61);
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'hFF);
        push_resp(8'h40, 0);
        for (int i = 1; i <= 4; i++) begin
            push_resp(8'(i), 0);
            exp_rx_q.push_back(8'(i));
        end
        req = 2'b10;
        got = 0;
        n   = 0;
        while (got < 2 && n < 500) begin
            @(negedge clk_10);
            n++;
            if (rx_valid) got++;
        end
        chk("t7_reached_data", got, 2);
        repeat (2) @(negedge clk_10);
        #10 rst = 1'b1;
        #1;
        chk("midrst_csn",   int'(csn), 1);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_pulses", int'({eng_start, tx_take, rx_valid, done, err, busy}), 0);
        chk("midrst_bytes",  int'({eng_tx, rx_data, status}), 0);
        req = 2'b00;
        exp_tx_q.delete();
        exp_rx_q.delete();
        resp_q.delete();
        txq.delete();
        repeat (6) @(negedge clk_10);
        rst = 1'b0;
        repeat (2) @(negedge clk_10);

        // 8: after reset requester 0 wins a tie
        req0_cmd = R_REGISTER; req0_len = 6'd0;
        exp_tx_q.push_back(8'h00);
        push_resp(8'h0E, 0);
        push_exp(2'b01, 8'h0E, 0, 0, 1);
        req = 2'b11;
        wait_done("t8_done");
        req = 2'b00;

        repeat (10) @(negedge clk_10);
        chk("exp_done_left", exp_q.size(), 0);
        chk("exp_rx_left",   exp_rx_q.size(), 0);
        chk("exp_tx_left",   exp_tx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
